// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared SDRAM slave port.
// Define WSHB_ARB_FIXED_PRIO_EN for fixed m0-first tie-breaking; default is round-robin.
module wshb_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  output logic [1:0]              grant
);

  // state | meaning
  // IDLE  | no owner, slave port driven to zero
  // GNT0  | m0 owns the slave port until m0_cyc drops
  // GNT1  | m1 owns the slave port until m1_cyc drops
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state;
  logic   pick_m1;

`ifdef WSHB_ARB_FIXED_PRIO_EN
  assign pick_m1 = m1_cyc & ~m0_cyc;
`else
  logic last_m1;

  // Reset value 1 makes m0 the winner of the first tie.
  assign pick_m1 = m1_cyc & (~m0_cyc | ~last_m1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      last_m1 <= 1'b1;
    else if (state == IDLE && (m0_cyc || m1_cyc))
      last_m1 <= pick_m1;
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pick_m1)     state <= GNT1;
          else if (m0_cyc) state <= GNT0;
        end
        GNT0:    if (!m0_cyc) state <= IDLE;
        GNT1:    if (!m1_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign grant     = {state == GNT1, state == GNT0};
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Terminations are also gated by the owner's cyc so a late ack after an abort is dropped.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack & m0_cyc;
        m0_err   = s_err & m0_cyc;
        m0_rty   = s_rty & m0_cyc;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack & m1_cyc;
        m1_err   = s_err & m1_cyc;
        m1_rty   = s_rty & m1_cyc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: vector table for grant/routing plus burst and reset sequences.
module tb_wshb_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_dat_ms, m1_dat_ms;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat_sm;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

  wshb_arbiter #(.DATA_BYTES(4), .ADDR_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        c0, c1, ack, err;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_ack0, e_ack1, e_err0, e_err1;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic c0, c1, ack, err, input logic [1:0] g,
                              input logic sc, input logic [31:0] a, input logic [3:0] sl,
                              input logic a0, a1, e0, e1);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.ack = ack; v.err = err;
    v.e_grant = g; v.e_scyc = sc; v.e_adr = a; v.e_sel = sl;
    v.e_ack0 = a0; v.e_ack1 = a1; v.e_err0 = e0; v.e_err1 = e1;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(0,0,0,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);
    vt[1]  = mk(1,1,1,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);
    vt[2]  = mk(1,1,1,0, 2'b01,1,32'h100,4'hF, 1,0,0,0);
    vt[3]  = mk(0,1,1,0, 2'b01,0,32'h100,4'hF, 0,0,0,0);
    vt[4]  = mk(0,1,0,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);
    vt[5]  = mk(1,1,1,0, 2'b10,1,32'h200,4'h3, 0,1,0,0);
    vt[6]  = mk(1,1,0,1, 2'b10,1,32'h200,4'h3, 0,0,0,1);
    vt[7]  = mk(1,0,0,0, 2'b10,0,32'h200,4'h3, 0,0,0,0);
    vt[8]  = mk(1,1,0,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);
    vt[9]  = mk(0,1,0,0, 2'b01,0,32'h100,4'hF, 0,0,0,0);
    vt[10] = mk(1,1,0,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);
`ifdef WSHB_ARB_FIXED_PRIO_EN
    vt[11] = mk(1,1,0,0, 2'b01,1,32'h100,4'hF, 0,0,0,0);
    vt[12] = mk(0,0,0,0, 2'b01,0,32'h100,4'hF, 0,0,0,0);
`else
    vt[11] = mk(1,1,0,0, 2'b10,1,32'h200,4'h3, 0,0,0,0);
    vt[12] = mk(0,0,0,0, 2'b10,0,32'h200,4'h3, 0,0,0,0);
`endif
    vt[13] = mk(0,0,0,0, 2'b00,0,32'h0,  4'h0, 0,0,0,0);

    sys_rst = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100; m0_dat_ms = 32'h11110000;
    m0_sel = 4'hF; m0_cti = 3'b000; m0_bte = 2'b00;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h200; m1_dat_ms = 32'h22220000;
    m1_sel = 4'h3; m1_cti = 3'b000; m1_bte = 2'b00;
    s_ack = 1; s_err = 0; s_rty = 0; s_dat_sm = 32'hDEADBEEF;

    repeat (2) @(negedge sys_clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_scyc", {31'd0, s_cyc}, 32'd0);
    chk("rst_sadr", s_adr, 32'd0);
    chk("rst_m0ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_m1ack", {31'd0, m1_ack}, 32'd0);
    m0_cyc = 0; m1_cyc = 0; s_ack = 0;
    sys_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge sys_clk);
      m0_cyc = vt[i].c0; m0_stb = vt[i].c0;
      m1_cyc = vt[i].c1; m1_stb = vt[i].c1;
      s_ack = vt[i].ack; s_err = vt[i].err;
      #1;
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vt[i].e_grant});
      chk($sformatf("v%0d_scyc", i), {31'd0, s_cyc}, {31'd0, vt[i].e_scyc});
      chk($sformatf("v%0d_sadr", i), s_adr, vt[i].e_adr);
      chk($sformatf("v%0d_ssel", i), {28'd0, s_sel}, {28'd0, vt[i].e_sel});
      chk($sformatf("v%0d_m0ack", i), {31'd0, m0_ack}, {31'd0, vt[i].e_ack0});
      chk($sformatf("v%0d_m1ack", i), {31'd0, m1_ack}, {31'd0, vt[i].e_ack1});
      chk($sformatf("v%0d_m0err", i), {31'd0, m0_err}, {31'd0, vt[i].e_err0});
      chk($sformatf("v%0d_m1err", i), {31'd0, m1_err}, {31'd0, vt[i].e_err1});
      chk($sformatf("v%0d_m0dat", i), m0_dat_sm, 32'hDEADBEEF);
      chk($sformatf("v%0d_m1dat", i), m1_dat_sm, 32'hDEADBEEF);
    end
    s_ack = 0; s_err = 0;

    // m0 eight-beat incrementing burst; m1 joins at beat 3 and must stall.
    @(negedge sys_clk);
    m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010;
    for (int b = 0; b < 8; b++) begin
      @(negedge sys_clk);
      if (b == 3) begin m1_cyc = 1; m1_stb = 1; end
      s_ack = 1;
      if (b == 7) m0_cti = 3'b111;
      #1;
      chk($sformatf("burst%0d_grant", b), {30'd0, grant}, 32'd1);
      chk($sformatf("burst%0d_m0ack", b), {31'd0, m0_ack}, 32'd1);
      chk($sformatf("burst%0d_m1ack", b), {31'd0, m1_ack}, 32'd0);
      if (b == 0) chk("burst_scti", {29'd0, s_cti}, 32'd2);
    end
    @(negedge sys_clk);
    m0_cyc = 0; m0_stb = 0; m0_cti = 3'b000;
    #1;
    chk("burst_drop_scyc", {31'd0, s_cyc}, 32'd0);
    chk("burst_drop_m0ack", {31'd0, m0_ack}, 32'd0);
    begin
      int k;
      k = 0;
      for (int j = 1; j <= 5; j++) begin
        @(negedge sys_clk); #1;
        if (grant == 2'b10) begin k = j; break; end
        chk($sformatf("burst_wait%0d_m1ack", j), {31'd0, m1_ack}, 32'd0);
      end
      chk("burst_m1_grant_delay", k, 2);
    end
    s_ack = 0;
    chk("burst_m1_sadr", s_adr, 32'h200);
    chk("burst_m1_swe", {31'd0, s_we}, 32'd1);

    // Reset while m1 owns the bus with an ack arriving.
    @(negedge sys_clk);
    #1;
    chk("rstmid_pre_grant", {30'd0, grant}, 32'd2);
    sys_rst = 1'b1;
    s_ack = 1;
    #1;
    chk("rstmid_grant", {30'd0, grant}, 32'd0);
    chk("rstmid_scyc", {31'd0, s_cyc}, 32'd0);
    chk("rstmid_m1ack", {31'd0, m1_ack}, 32'd0);
    @(negedge sys_clk);
    #1;
    chk("rstmid_hold_m1ack", {31'd0, m1_ack}, 32'd0);
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    sys_rst = 1'b0;
    @(negedge sys_clk); #1;
    chk("rstmid_tie_grant", {30'd0, grant}, 32'd1);
    chk("rstmid_tie_sadr", s_adr, 32'h100);

    @(negedge sys_clk);
    m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0;
    @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
